fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 156 +++++++++++++++
 tb/tb_fwd_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Register scoreboard and operand bypass selector for an in-order,
//   multi-lane issue stage. Each architectural register r (1..31) owns a
//   small down-counter holding the cycles left until its pending result
//   appears on a bypass bus. A lane may issue only when none of its
//   register sources is still counting down, when no older lane in the
//   same bundle writes one of them, and when every older lane may issue.
//   Operand data is picked from the youngest matching bypass bus,
//   falling back to the register-file read data.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   src_addr/imm/rf    per lane, per operand: source address, immediate
//                      flag, register-file read data
//   iss_valid/we/dst/lat  per lane issue request and destination info
//   pipe_hold, flush   downstream freeze, pipeline flush
//   byp_valid/addr/data   per stage, per lane bypass buses
//   iss_ready          per lane issue permission (combinational)
//   fwd_data           per lane, per operand forwarded data
//   busy_vec           one bit per register, set while its counter is nonzero
//   stall_cnt          saturating count of lane-0 hazard stall cycles
//
// Flat vector layout: lane k operand o sits at slot k*2+o; bypass stage s
// lane l sits at slot s*ISSUE_NUM+l. CNT_W sets the internal width of the
// stall counter (saturating at its all-ones value), zero-extended onto
// the 32-bit stall_cnt port.

module fwd_scoreboard #(
    parameter int ISSUE_NUM = 2,
    parameter int STAGE_NUM = 5,
    parameter int DW        = 32,
    parameter int LAT_W     = 3,
    parameter int CNT_W     = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [ISSUE_NUM*2*5-1:0]        src_addr,
    input  logic [ISSUE_NUM*2-1:0]          src_imm,
    input  logic [ISSUE_NUM*2*DW-1:0]       src_rf_data,
    input  logic [ISSUE_NUM-1:0]            iss_valid,
    input  logic [ISSUE_NUM-1:0]            iss_we,
    input  logic [ISSUE_NUM*5-1:0]          iss_dst,
    input  logic [ISSUE_NUM*LAT_W-1:0]      iss_lat,
    input  logic                            pipe_hold,
    input  logic                            flush,
    input  logic [STAGE_NUM*ISSUE_NUM-1:0]    byp_valid,
    input  logic [STAGE_NUM*ISSUE_NUM*5-1:0]  byp_addr,
    input  logic [STAGE_NUM*ISSUE_NUM*DW-1:0] byp_data,
    output logic [ISSUE_NUM-1:0]            iss_ready,
    output logic [ISSUE_NUM*2*DW-1:0]       fwd_data,
    output logic [31:0]                     busy_vec,
    output logic [31:0]                     stall_cnt
);

    logic [LAT_W-1:0] pend_cnt [32];
    logic [LAT_W-1:0] pend_nxt [32];
    logic [CNT_W-1:0] stall_q;

    logic       hz_chain;
    logic       hz_ok;
    logic [4:0] hz_a;
    logic       fw_hit;
    logic [4:0] fw_a;

    // Issue permission: ready ripples from lane 0 upward so a blocked lane
    // also blocks every younger lane (in-order issue).
    always_comb begin
        iss_ready = '0;
        hz_chain  = resetn & ~flush & ~pipe_hold;
        hz_ok     = 1'b0;
        hz_a      = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            hz_ok = hz_chain;
            for (int o = 0; o < 2; o++) begin
                hz_a = src_addr[(k*2+o)*5 +: 5];
                if (!src_imm[k*2+o] && hz_a != 5'd0) begin
                    if (pend_cnt[hz_a] != '0) hz_ok = 1'b0;
                    // Older lane in the same bundle produces this source;
                    // its latency is irrelevant, the value cannot exist yet.
                    for (int j = 0; j < ISSUE_NUM; j++) begin
                        if (j < k && iss_valid[j] && iss_we[j] &&
                            iss_dst[j*5 +: 5] == hz_a)
                            hz_ok = 1'b0;
                    end
                end
            end
            iss_ready[k] = hz_ok;
            hz_chain     = hz_ok;
        end
    end

    // Bypass select: youngest stage first; within a stage the highest lane
    // (youngest instruction of that bundle) wins.
    always_comb begin
        fwd_data = src_rf_data;
        fw_hit   = 1'b0;
        fw_a     = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            for (int o = 0; o < 2; o++) begin
                fw_a   = src_addr[(k*2+o)*5 +: 5];
                fw_hit = 1'b0;
                if (!src_imm[k*2+o] && fw_a != 5'd0) begin
                    for (int s = 0; s < STAGE_NUM; s++) begin
                        for (int l = ISSUE_NUM - 1; l >= 0; l--) begin
                            if (!fw_hit && byp_valid[s*ISSUE_NUM+l] &&
                                byp_addr[(s*ISSUE_NUM+l)*5 +: 5] == fw_a) begin
                                fwd_data[(k*2+o)*DW +: DW] =
                                    byp_data[(s*ISSUE_NUM+l)*DW +: DW];
                                fw_hit = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Counter update for an advancing pipeline: age everything by one, then
    // newly fired writers overwrite. Lanes are visited oldest to youngest so
    // the youngest writer of a register wins.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pend_nxt[r] = (pend_cnt[r] != '0) ? pend_cnt[r] - LAT_W'(1) : '0;
        end
        for (int k = 0; k < ISSUE_NUM; k++) begin
            if (iss_valid[k] && iss_ready[k] && iss_we[k] &&
                iss_dst[k*5 +: 5] != 5'd0)
                pend_nxt[iss_dst[k*5 +: 5]] = iss_lat[k*LAT_W +: LAT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < 32; r++) pend_cnt[r] <= '0;
            stall_q <= '0;
        end else begin
            if (flush) begin
                for (int r = 0; r < 32; r++) pend_cnt[r] <= '0;
            end else if (!pipe_hold) begin
                for (int r = 1; r < 32; r++) pend_cnt[r] <= pend_nxt[r];
                pend_cnt[0] <= '0;
            end
            if (iss_valid[0] && !iss_ready[0] && !flush && !pipe_hold &&
                stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < 32; r++) busy_vec[r] = (pend_cnt[r] != '0);
    end

    assign stall_cnt = 32'(stall_q);

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard. The driver applies directed vectors
// once per cycle (just after the rising edge) and queues the hand-computed
// expected values tagged with the cycle number; the monitor samples on the
// falling edge and retires every queued expectation for that cycle.
// The stall counter is built 4 bits wide here so its saturation is reachable.

module tb_fwd_scoreboard;

    localparam int NI = 2;
    localparam int NS = 5;
    localparam int W  = 32;
    localparam int LW = 3;
    localparam int CW = 4;

    logic                 clk = 1'b1;
    logic                 resetn;
    logic [NI*2*5-1:0]    src_addr;
    logic [NI*2-1:0]      src_imm;
    logic [NI*2*W-1:0]    src_rf_data;
    logic [NI-1:0]        iss_valid;
    logic [NI-1:0]        iss_we;
    logic [NI*5-1:0]      iss_dst;
    logic [NI*LW-1:0]     iss_lat;
    logic                 pipe_hold;
    logic                 flush;
    logic [NS*NI-1:0]     byp_valid;
    logic [NS*NI*5-1:0]   byp_addr;
    logic [NS*NI*W-1:0]   byp_data;
    logic [NI-1:0]        iss_ready;
    logic [NI*2*W-1:0]    fwd_data;
    logic [31:0]          busy_vec;
    logic [31:0]          stall_cnt;

    fwd_scoreboard #(
        .ISSUE_NUM(NI), .STAGE_NUM(NS), .DW(W), .LAT_W(LW), .CNT_W(CW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .src_addr(src_addr), .src_imm(src_imm), .src_rf_data(src_rf_data),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_dst(iss_dst),
        .iss_lat(iss_lat), .pipe_hold(pipe_hold), .flush(flush),
        .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
        .iss_ready(iss_ready), .fwd_data(fwd_data),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int es;

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 iss_ready, 1 fwd lane0 op0, 2 fwd lane1 op0, 3 busy_vec, 4 stall_cnt
    function automatic logic [31:0] pick(int kind);
        case (kind)
            0:       return {30'b0, iss_ready};
            1:       return fwd_data[0 +: 32];
            2:       return fwd_data[2*W +: 32];
            3:       return busy_vec;
            4:       return stall_cnt;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e   = q.pop_front();
            mon_act = pick(mon_e.kind);
            total++;
            if (mon_act !== mon_e.exp) begin
                bad++;
                $display("FAIL %s (cycle %0d): got %h expected %h",
                         mon_e.nm, cyc, mon_act, mon_e.exp);
            end
        end
    end

    task automatic chk(int kind, logic [31:0] exp, string nm);
        q.push_back('{cyc, kind, exp, nm});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        iss_valid = '0; iss_we = '0; iss_dst = '0; iss_lat = '0;
        src_addr = '0; src_imm = '0; src_rf_data = '0;
        byp_valid = '0; byp_addr = '0; byp_data = '0;
        pipe_hold = 1'b0; flush = 1'b0;
    endtask

    // Valid reader on lane k, operand o.
    task automatic rd(int k, int o, logic [4:0] a, logic imm, logic [31:0] rf);
        iss_valid[k] = 1'b1;
        src_addr[(k*2+o)*5 +: 5] = a;
        src_imm[k*2+o] = imm;
        src_rf_data[(k*2+o)*W +: W] = rf;
    endtask

    task automatic wr(int k, logic [4:0] d, logic [LW-1:0] lat);
        iss_valid[k] = 1'b1;
        iss_we[k] = 1'b1;
        iss_dst[k*5 +: 5] = d;
        iss_lat[k*LW +: LW] = lat;
    endtask

    task automatic byp(int s, int l, logic [4:0] a, logic [31:0] d);
        byp_valid[s*NI+l] = 1'b1;
        byp_addr[(s*NI+l)*5 +: 5] = a;
        byp_data[(s*NI+l)*W +: W] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        resetn = 1'b0; clr(); rd(0, 0, 5'd0, 1'b0, 32'h0);
        chk(0, 32'h0, "rst_ready"); step();
        chk(0, 32'h0, "rst_ready2"); chk(3, 32'h0, "rst_busy"); chk(4, 32'h0, "rst_stall"); step();
        resetn = 1'b1; clr();
        chk(0, 32'h3, "idle_ready"); step();

        // latency-0 write, immediate bypass read
        clr(); wr(0, 5'd5, 3'd0); chk(0, 32'h3, "w5_ready"); step();
        clr(); rd(0, 0, 5'd5, 1'b0, 32'hDEAD); byp(0, 0, 5'd5, 32'h1234);
        chk(0, 32'h3, "r5_ready"); chk(1, 32'h1234, "r5_fwd"); chk(3, 32'h0, "r5_busy"); step();

        // latency-2 load, dependent reader stalls two cycles
        clr(); wr(0, 5'd7, 3'd2); chk(0, 32'h3, "w7_ready"); step();
        clr(); rd(0, 0, 5'd7, 1'b0, 32'hCAFE);
        chk(0, 32'h0, "r7_stall1"); chk(3, 32'h80, "r7_busy1"); step();
        chk(0, 32'h0, "r7_stall2"); chk(3, 32'h80, "r7_busy2"); chk(4, 32'h1, "r7_cnt1"); step();
        chk(0, 32'h3, "r7_go"); chk(3, 32'h0, "r7_busy0"); chk(4, 32'h2, "r7_cnt2");
        chk(1, 32'hCAFE, "r7_rf_fallback"); step();

        // intra-bundle RAW
        clr(); wr(0, 5'd3, 3'd1); rd(1, 0, 5'd3, 1'b0, 32'h0);
        chk(0, 32'h1, "raw_ready"); step();
        clr(); wr(0, 5'd3, 3'd1); rd(1, 0, 5'd4, 1'b0, 32'h0);
        chk(0, 32'h3, "noraw_ready"); step();

        // bypass priority, r0 and immediate operands
        clr(); rd(0, 0, 5'd9, 1'b0, 32'h55); rd(1, 0, 5'd0, 1'b0, 32'h77);
        byp(0, 1, 5'd9, 32'hAA); byp(2, 0, 5'd9, 32'hBB); byp(1, 0, 5'd0, 32'hCC);
        chk(1, 32'hAA, "byp_youngest"); chk(2, 32'h77, "byp_r0"); chk(3, 32'h8, "busy_r3"); step();
        clr(); rd(0, 0, 5'd9, 1'b0, 32'h55); rd(1, 0, 5'd9, 1'b1, 32'h66);
        byp(2, 0, 5'd9, 32'hBB); byp(2, 1, 5'd9, 32'hDD);
        chk(1, 32'hDD, "byp_lane_order"); chk(2, 32'h66, "byp_imm"); chk(3, 32'h0, "busy_r3_done"); step();

        // WAW inside a bundle: lane 1 latency wins
        clr(); wr(0, 5'd10, 3'd1); wr(1, 5'd10, 3'd3); chk(0, 32'h3, "waw_ready"); step();
        clr(); chk(3, 32'h400, "waw_busy1"); step();
        chk(3, 32'h400, "waw_busy2"); step();

        // hold freezes counters and stall count, flush clears
        clr(); wr(0, 5'd7, 3'd3); step();
        clr(); pipe_hold = 1'b1; rd(0, 0, 5'd7, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk(3, 32'h80, "hold_busy"); chk(4, 32'h2, "hold_stall"); chk(0, 32'h0, "hold_ready"); step();
        end
        pipe_hold = 1'b0; flush = 1'b1; chk(0, 32'h0, "flush_ready"); step();
        flush = 1'b0;
        chk(0, 32'h3, "post_flush_ready"); chk(3, 32'h0, "post_flush_busy"); chk(4, 32'h2, "post_flush_stall"); step();

        // stall counter saturation
        es = 2;
        repeat (2) begin
            clr(); wr(0, 5'd7, 3'd7); chk(4, 32'(es), "sat_cnt"); step();
            clr(); rd(0, 0, 5'd7, 1'b0, 32'h0);
            for (int i = 0; i < 7; i++) begin
                chk(0, 32'h0, "sat_stall_ready"); step();
            end
            es = (es + 7 > 15) ? 15 : es + 7;
        end
        clr(); wr(0, 5'd7, 3'd7); chk(4, 32'(es), "sat_full"); step();
        clr(); rd(0, 0, 5'd7, 1'b0, 32'h0); chk(0, 32'h0, "sat_more_ready"); step();
        chk(4, 32'hF, "sat_stay"); chk(3, 32'h80, "mid_busy"); step();

        // reset in the middle of a stall
        resetn = 1'b0; chk(0, 32'h0, "rst_mid_ready"); step();
        resetn = 1'b1;
        chk(0, 32'h3, "rst_rel_ready"); chk(3, 32'h0, "rst_rel_busy"); chk(4, 32'h0, "rst_rel_stall"); step();
        clr(); step(); step();

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
